// File: rtl/feature_pkg.sv
// Shared types and constants for the feature fetch path: record field layout,
// widths and the saturating counter arithmetic.
package feature_pkg;

    localparam int unsigned REC_W   = 192;
    localparam int unsigned VEC_W   = 160;
    localparam int unsigned META_W  = 128;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned TAG_W   = 32;

    localparam logic [7:0] MIN_INIT = 8'hFF;

    localparam int unsigned MAX_SIZE_LSB  = 0;
    localparam int unsigned MIN_SIZE_LSB  = 8;
    localparam int unsigned MAX_ARIT_LSB  = 16;
    localparam int unsigned MIN_ARIT_LSB  = 24;
    localparam int unsigned N_PKT_LSB     = 32;
    localparam int unsigned FLOW_DURT_LSB = 40;
    localparam int unsigned FLOW_SIZE_LSB = 48;
    localparam int unsigned REC_VALID_BIT = 56;
    localparam int unsigned TAG_LSB       = 64;

    typedef struct packed {
        logic [TAG_W-1:0]   hash;
        logic [FIELD_W-1:0] pkt_size;
        logic [FIELD_W-1:0] pkt_arit;
        logic [META_W-1:0]  meta;
    } req_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/feature_fetch_unit_if.sv
// Per-packet request channel into the feature fetch unit.
interface feature_fetch_unit_if;
    import feature_pkg::*;

    logic               i_req_v;
    logic               i_req_rdy;
    logic [TAG_W-1:0]   i_hash;
    logic [FIELD_W-1:0] i_pkt_size;
    logic [FIELD_W-1:0] i_pkt_arit;
    logic [META_W-1:0]  i_meta;

    modport master (
        output i_req_v, i_hash, i_pkt_size, i_pkt_arit, i_meta,
        input  i_req_rdy
    );

    modport slave (
        input  i_req_v, i_hash, i_pkt_size, i_pkt_arit, i_meta,
        output i_req_rdy
    );

endinterface

// File: rtl/pending_addr_table.sv
// Tracks cache indices issued but not yet written back, to stall read-after-write
// hazards on the same flow.
module pending_addr_table #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_idx,
    input  logic              insert,
    input  logic              clear,
    input  logic [ADDR_W-1:0] clear_idx,
    output logic              full,
    output logic              match
);
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    logic [ADDR_W-1:0] idx_q [MAX_OUT];
    logic [ADDR_W-1:0] idx_d [MAX_OUT];
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              clr_hit;
    logic [CntW-1:0]   clr_pos;
    logic [CntW-1:0]   ins_pos;

    assign full = (cnt_q == CntW'(MAX_OUT));

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (CntW'(i) < cnt_q && idx_q[i] == req_idx) match = 1'b1;
        end
    end

    // Slots are kept packed oldest-first, so the lowest matching slot is the oldest.
    always_comb begin
        clr_hit = 1'b0;
        clr_pos = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (CntW'(i) < cnt_q && idx_q[i] == clear_idx) begin
                clr_hit = 1'b1;
                clr_pos = CntW'(i);
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (clear && clr_hit) begin
            for (int i = 0; i < MAX_OUT - 1; i++) begin
                if (CntW'(i) >= clr_pos) idx_d[i] = idx_q[i + 1];
            end
            cnt_d = cnt_q - CntW'(1);
        end
        ins_pos = cnt_d;
        if (insert) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (CntW'(i) == ins_pos) idx_d[i] = req_idx;
            end
            cnt_d = cnt_d + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < MAX_OUT; i++) idx_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/feature_fetch_unit.sv
// Read-side front end of the feature path: fetches the flow record, checks the tag
// and issues updated history plus packet fields to the ALU cluster.
module feature_fetch_unit
    import feature_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    feature_fetch_unit_if.slave  req,
    input  logic [7:0]           threshold,
    output logic [31:0]          rcache_addr,
    output logic                 rcache_en,
    input  logic [REC_W-1:0]     rcache_data,
    input  logic [VEC_W-1:0]     rvec_data,
    input  logic [31:0]          wcache_addr,
    input  logic                 wea_cache,
    output logic [7:0]           hist_max_pkt_size,
    output logic [7:0]           hist_min_pkt_size,
    output logic [7:0]           hist_max_pkt_arit,
    output logic [7:0]           hist_min_pkt_arit,
    output logic                 hist_data_v,
    output logic [VEC_W-1:0]     o_vec_feature,
    output logic [7:0]           pkt_size,
    output logic [7:0]           pkt_arit,
    output logic [7:0]           n_pkt,
    output logic [7:0]           flow_durt,
    output logic [7:0]           flow_size,
    output logic [31:0]          o_hash,
    output logic                 size_arit_v,
    output logic                 reach_thrh,
    output logic [META_W-1:0]    o_meta,
    output logic                 o_meta_v
);
    logic [ADDR_W-1:0] req_idx;
    logic              tbl_full, tbl_match, accept;
    req_t              in_req, tail;
    req_t              pipe_q [RD_LAT];
    logic [RD_LAT-1:0] pipe_v_q;
    logic              tail_v, rec_hit;
    logic [7:0]        n_pkt_d, flow_durt_d, flow_size_d;
    logic              unused;

    assign req_idx       = req.i_hash[ADDR_W-1:0];
    assign req.i_req_rdy = !rst && !tbl_full && !tbl_match;
    assign accept        = req.i_req_v && req.i_req_rdy;
    assign rcache_en     = accept;
    assign rcache_addr   = accept ? {{(32 - ADDR_W){1'b0}}, req_idx} : 32'd0;
    assign in_req        = '{hash: req.i_hash, pkt_size: req.i_pkt_size,
                             pkt_arit: req.i_pkt_arit, meta: req.i_meta};
    assign unused        = ^{rcache_data[REC_W-1:96], rcache_data[63:57],
                             wcache_addr[31:ADDR_W]};

    pending_addr_table #(
        .ADDR_W  (ADDR_W),
        .MAX_OUT (MAX_OUT)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .req_idx   (req_idx),
        .insert    (accept),
        .clear     (wea_cache),
        .clear_idx (wcache_addr[ADDR_W-1:0]),
        .full      (tbl_full),
        .match     (tbl_match)
    );

    // Request fields travel alongside the cache read so they line up with returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_v_q[0] <= accept;
            pipe_q[0]   <= in_req;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_q[i]   <= pipe_q[i-1];
            end
        end
    end

    assign tail    = pipe_q[RD_LAT-1];
    assign tail_v  = pipe_v_q[RD_LAT-1];
    assign rec_hit = rcache_data[REC_VALID_BIT] &&
                     (rcache_data[TAG_LSB +: TAG_W] == tail.hash);

    // A tag mismatch evicts the old flow, so it starts fresh exactly like a miss.
    always_comb begin
        n_pkt_d     = 8'd1;
        flow_durt_d = 8'd0;
        flow_size_d = tail.pkt_size;
        if (rec_hit) begin
            n_pkt_d     = sat_add8(rcache_data[N_PKT_LSB +: FIELD_W], 8'd1);
            flow_durt_d = sat_add8(rcache_data[FLOW_DURT_LSB +: FIELD_W], tail.pkt_arit);
            flow_size_d = sat_add8(rcache_data[FLOW_SIZE_LSB +: FIELD_W], tail.pkt_size);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_data_v       <= 1'b0;
            reach_thrh        <= 1'b0;
            hist_max_pkt_size <= 8'd0;
            hist_min_pkt_size <= MIN_INIT;
            hist_max_pkt_arit <= 8'd0;
            hist_min_pkt_arit <= MIN_INIT;
            o_vec_feature     <= '0;
            pkt_size          <= 8'd0;
            pkt_arit          <= 8'd0;
            n_pkt             <= 8'd0;
            flow_durt         <= 8'd0;
            flow_size         <= 8'd0;
            o_hash            <= 32'd0;
            o_meta            <= '0;
        end else begin
            hist_data_v <= tail_v;
            reach_thrh  <= tail_v && (threshold != 8'd0) && (n_pkt_d == threshold);
            if (tail_v) begin
                hist_max_pkt_size <= rec_hit ? rcache_data[MAX_SIZE_LSB +: FIELD_W] : 8'd0;
                hist_min_pkt_size <= rec_hit ? rcache_data[MIN_SIZE_LSB +: FIELD_W] : MIN_INIT;
                hist_max_pkt_arit <= rec_hit ? rcache_data[MAX_ARIT_LSB +: FIELD_W] : 8'd0;
                hist_min_pkt_arit <= rec_hit ? rcache_data[MIN_ARIT_LSB +: FIELD_W] : MIN_INIT;
                o_vec_feature     <= rec_hit ? rvec_data : '0;
                pkt_size          <= tail.pkt_size;
                pkt_arit          <= tail.pkt_arit;
                n_pkt             <= n_pkt_d;
                flow_durt         <= flow_durt_d;
                flow_size         <= flow_size_d;
                o_hash            <= tail.hash;
                o_meta            <= tail.meta;
            end
        end
    end

    assign size_arit_v = hist_data_v;
    assign o_meta_v    = hist_data_v;

endmodule

// File: tb/tb_feature_fetch_unit.sv
// Directed self-checking bench for feature_fetch_unit with a fixed-latency cache model.
module tb_feature_fetch_unit;
    import feature_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    feature_fetch_unit_if req_if ();

    logic [7:0]   threshold;
    logic [31:0]  rcache_addr, wcache_addr, o_hash;
    logic         rcache_en, wea_cache;
    logic [191:0] rcache_data;
    logic [159:0] rvec_data, o_vec_feature;
    logic [7:0]   hmax_s, hmin_s, hmax_a, hmin_a, pkt_size, pkt_arit, n_pkt, flow_durt, flow_size;
    logic         hist_data_v, size_arit_v, reach_thrh, o_meta_v;
    logic [127:0] o_meta;

    feature_fetch_unit #(.ADDR_W(10), .RD_LAT(2), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .req(req_if), .threshold(threshold),
        .rcache_addr(rcache_addr), .rcache_en(rcache_en),
        .rcache_data(rcache_data), .rvec_data(rvec_data),
        .wcache_addr(wcache_addr), .wea_cache(wea_cache),
        .hist_max_pkt_size(hmax_s), .hist_min_pkt_size(hmin_s),
        .hist_max_pkt_arit(hmax_a), .hist_min_pkt_arit(hmin_a),
        .hist_data_v(hist_data_v), .o_vec_feature(o_vec_feature),
        .pkt_size(pkt_size), .pkt_arit(pkt_arit), .n_pkt(n_pkt),
        .flow_durt(flow_durt), .flow_size(flow_size), .o_hash(o_hash),
        .size_arit_v(size_arit_v), .reach_thrh(reach_thrh),
        .o_meta(o_meta), .o_meta_v(o_meta_v)
    );

    // Cache model: data for an address appears two cycles after it is presented.
    logic [191:0] mem_rec [1024];
    logic [159:0] mem_vec [1024];
    logic [9:0]   a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= rcache_addr[9:0];
        a2 <= a1;
    end
    assign rcache_data = mem_rec[a2];
    assign rvec_data   = mem_vec[a2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int k = 0;
        while (req_if.i_req_rdy !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_rdy"}, req_if.i_req_rdy, 1'b1);
    endtask

    task automatic drive(input logic [31:0] h, input logic [7:0] s, input logic [7:0] a,
                         input logic [127:0] m);
        req_if.i_hash     = h;
        req_if.i_pkt_size = s;
        req_if.i_pkt_arit = a;
        req_if.i_meta     = m;
    endtask

    // Accept one request; returns one cycle after the accept edge.
    task automatic send(input string tag, input logic [31:0] h, input logic [7:0] s,
                        input logic [7:0] a, input logic [127:0] m);
        drive(h, s, a, m);
        req_if.i_req_v = 1'b1;
        #1;
        wait_rdy(tag);
        check({tag, "_rd_en"}, rcache_en, 1'b1);
        check({tag, "_rd_addr"}, rcache_addr, {22'd0, h[9:0]});
        @(posedge clk); #1;
        req_if.i_req_v = 1'b0;
    endtask

    task automatic write_back(input logic [31:0] addr);
        wcache_addr = addr;
        wea_cache   = 1'b1;
        @(posedge clk); #1;
        wea_cache   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] mxs, input logic [7:0] mns,
                              input logic [7:0] mxa, input logic [7:0] mna,
                              input logic [7:0] np, input logic [7:0] du, input logic [7:0] fs,
                              input logic [7:0] ps, input logic [7:0] pa, input logic [31:0] h,
                              input logic [159:0] vec, input logic [127:0] m, input logic thr);
        @(posedge clk); #1;
        check({tag, "_early_v"}, hist_data_v, 1'b0);
        @(posedge clk); #1;
        check({tag, "_v"}, hist_data_v, 1'b1);
        check({tag, "_sa_v"}, size_arit_v, 1'b1);
        check({tag, "_meta_v"}, o_meta_v, 1'b1);
        check({tag, "_max_size"}, hmax_s, mxs);
        check({tag, "_min_size"}, hmin_s, mns);
        check({tag, "_max_arit"}, hmax_a, mxa);
        check({tag, "_min_arit"}, hmin_a, mna);
        check({tag, "_n_pkt"}, n_pkt, np);
        check({tag, "_durt"}, flow_durt, du);
        check({tag, "_fsize"}, flow_size, fs);
        check({tag, "_psize"}, pkt_size, ps);
        check({tag, "_parit"}, pkt_arit, pa);
        check({tag, "_hash"}, o_hash, h);
        check({tag, "_vec"}, o_vec_feature, vec);
        check({tag, "_meta"}, o_meta, m);
        check({tag, "_thrh"}, reach_thrh, thr);
        @(posedge clk); #1;
        check({tag, "_late_v"}, hist_data_v, 1'b0);
        check({tag, "_late_thrh"}, reach_thrh, 1'b0);
    endtask

    logic [191:0] rec;
    logic [159:0] vec_a;
    int           seen;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_rec[i] = '0;
            mem_vec[i] = '0;
        end
        rst = 1'b1;
        req_if.i_req_v = 1'b0;
        drive(32'd0, 8'd0, 8'd0, 128'd0);
        threshold = 8'd0;
        wcache_addr = 32'd0;
        wea_cache = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_min_size", hmin_s, 8'hFF);
        check("rst_min_arit", hmin_a, 8'hFF);
        check("rst_max_size", hmax_s, 8'h00);
        check("rst_hist_v", hist_data_v, 1'b0);
        check("rst_n_pkt", n_pkt, 8'h00);
        check("rst_rd_en", rcache_en, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_rdy", req_if.i_req_rdy, 1'b1);

        // Miss on an empty record.
        send("miss", 32'h0000_0005, 8'd40, 8'd3, 128'hA5);
        expect_out("miss", 8'h00, 8'hFF, 8'h00, 8'hFF, 8'd1, 8'd0, 8'd40, 8'd40, 8'd3,
                   32'h0000_0005, 160'd0, 128'hA5, 1'b0);
        write_back(32'h0000_0005);

        // Hit: n_pkt 4->5 hits threshold, flow_size 250+10 saturates.
        threshold = 8'd5;
        rec = '0;
        rec[7:0] = 8'd60;  rec[15:8] = 8'd20; rec[23:16] = 8'd9; rec[31:24] = 8'd2;
        rec[39:32] = 8'd4; rec[47:40] = 8'd100; rec[55:48] = 8'd250; rec[56] = 1'b1;
        rec[95:64] = 32'hABCD_0012;
        vec_a = {32'hDEAD_BEEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        mem_rec[10'h12] = rec;
        mem_vec[10'h12] = vec_a;
        send("hit", 32'hABCD_0012, 8'd10, 8'd7, 128'h5A5A);
        expect_out("hit", 8'd60, 8'd20, 8'd9, 8'd2, 8'd5, 8'd107, 8'd255, 8'd10, 8'd7,
                   32'hABCD_0012, vec_a, 128'h5A5A, 1'b1);
        write_back(32'h0000_0012);

        // Same index, different tag: old flow evicted, starts fresh.
        send("evict", 32'h0000_0012, 8'd33, 8'd5, 128'h77);
        expect_out("evict", 8'h00, 8'hFF, 8'h00, 8'hFF, 8'd1, 8'd0, 8'd33, 8'd33, 8'd5,
                   32'h0000_0012, 160'd0, 128'h77, 1'b0);
        write_back(32'h0000_0012);

        // Hit with n_pkt and flow_durt both saturating.
        rec = '0;
        rec[7:0] = 8'd90; rec[15:8] = 8'd1; rec[23:16] = 8'd200; rec[31:24] = 8'd0;
        rec[39:32] = 8'd255; rec[47:40] = 8'd250; rec[55:48] = 8'd3; rec[56] = 1'b1;
        rec[95:64] = 32'h0000_0013;
        mem_rec[10'h13] = rec;
        mem_vec[10'h13] = 160'h1;
        send("sat", 32'h0000_0013, 8'd4, 8'd7, 128'h9);
        expect_out("sat", 8'd90, 8'd1, 8'd200, 8'd0, 8'd255, 8'd255, 8'd7, 8'd4, 8'd7,
                   32'h0000_0013, 160'h1, 128'h9, 1'b0);
        write_back(32'h0000_0013);

        // RAW hazard: same index stays blocked until its write-back has landed.
        send("raw_first", 32'h0000_0033, 8'd1, 8'd1, 128'h1);
        drive(32'h0000_0033, 8'd2, 8'd2, 128'h2);
        req_if.i_req_v = 1'b1;
        #1;
        check("raw_block", req_if.i_req_rdy, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("raw_block_hold", req_if.i_req_rdy, 1'b0);
        check("raw_no_rd_en", rcache_en, 1'b0);
        wcache_addr = 32'h0000_0033;
        wea_cache = 1'b1;
        #1;
        check("raw_same_cycle_wb", req_if.i_req_rdy, 1'b0);
        @(posedge clk); #1;
        wea_cache = 1'b0;
        #1;
        check("raw_released", req_if.i_req_rdy, 1'b1);
        check("raw_rd_en", rcache_en, 1'b1);
        @(posedge clk); #1;
        req_if.i_req_v = 1'b0;
        write_back(32'h0000_0033);
        repeat (3) @(posedge clk);
        #1;

        // Table full: four distinct indices outstanding, a fifth waits for a clear.
        for (int i = 0; i < 4; i++) begin
            drive(32'h40 + i, 8'd1, 8'd1, 128'd0);
            req_if.i_req_v = 1'b1;
            #1;
            check($sformatf("fill_%0d_rdy", i), req_if.i_req_rdy, 1'b1);
            @(posedge clk); #1;
        end
        drive(32'h44, 8'd1, 8'd1, 128'd0);
        #1;
        check("full_block", req_if.i_req_rdy, 1'b0);
        wcache_addr = 32'h41;
        wea_cache = 1'b1;
        #1;
        check("full_same_cycle", req_if.i_req_rdy, 1'b0);
        @(posedge clk); #1;
        wea_cache = 1'b0;
        #1;
        check("full_released", req_if.i_req_rdy, 1'b1);
        @(posedge clk); #1;
        req_if.i_req_v = 1'b0;
        write_back(32'h40);
        drive(32'h41, 8'd0, 8'd0, 128'd0);
        #1;
        check("tbl_41_free", req_if.i_req_rdy, 1'b1);
        drive(32'h42, 8'd0, 8'd0, 128'd0);
        #1;
        check("tbl_42_pending", req_if.i_req_rdy, 1'b0);
        drive(32'h44, 8'd0, 8'd0, 128'd0);
        #1;
        check("tbl_44_pending", req_if.i_req_rdy, 1'b0);
        write_back(32'h99);
        write_back(32'h42);
        write_back(32'h43);
        write_back(32'h44);
        repeat (3) @(posedge clk);
        #1;

        // Reset one cycle after accept: the request must never be issued.
        send("mid_rst", 32'h0000_0007, 8'd5, 8'd5, 128'h3);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (hist_data_v === 1'b1) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (hist_data_v === 1'b1) seen++;
        end
        check("mid_rst_no_issue", seen, 0);
        check("mid_rst_min_size", hmin_s, 8'hFF);
        check("mid_rst_min_arit", hmin_a, 8'hFF);
        drive(32'h0000_0007, 8'd5, 8'd5, 128'h3);
        #1;
        check("mid_rst_tbl_empty", req_if.i_req_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
